alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
Output-side counterpart of the ALU operand mux. It accepts one completed instruction result per handshake: an ALU result, a memory load, or an immediate. It registers the condition flags and drives the register-file write port. It also exposes a one-entry forwarding bypass, and stalls the front end while a load waits on memory.

Parameters:
DATA_W, 8, datapath width
ADDR_W, 3, register-file address width
MEM_TIMEOUT, 15, max cycles to wait for mem_rvalid before abort
ZERO_REG, 1, if 1 writes to address 0 are suppressed

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  result/instruction presented
in_ready  out  1  block can accept this cycle
src_sel  in  2  00 ALU, 01 MEM, 10 IMM, 11 none (no register write)
dest_addr  in  ADDR_W  destination register
reg_we  in  1  instruction writes a register
flag_we  in  1  instruction updates flags
alu_result  in  DATA_W  ALU output
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry-out
imm_value  in  DATA_W  immediate value
mem_rvalid  in  1  load data valid
mem_rdata  in  DATA_W  load data
rf_we  out  1  register-file write strobe
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
flag_zero  out  1  registered zero flag
flag_carry  out  1  registered carry flag
fwd_valid  out  1  bypass entry valid (equals rf_we)
fwd_addr  out  ADDR_W  bypass address (equals rf_waddr)
fwd_data  out  DATA_W  bypass data (equals rf_wdata)
mem_err  out  1  sticky load-timeout error

Behaviour:
- Reset (synchronous, active-high, clk edge): all outputs 0, state IDLE, timeout counter 0, in_ready 0 during the reset cycle.
- Handshake: accept when in_valid && in_ready. in_ready = 1 in IDLE, 0 in WAIT_MEM.
- States: IDLE, WAIT_MEM.
- IDLE, accepted src_sel 00/10/11:
  - rf_we = reg_we && src_sel!=11 && !(ZERO_REG && dest_addr==0) on cycle N+1, one cycle only.
  - rf_wdata = alu_result (00) or imm_value (10); rf_waddr = dest_addr.
  - Stay IDLE.
- Flags: if flag_we && src_sel==00 on accept, flag_zero/flag_carry load alu_zero/alu_carry at the same edge rf outputs update (visible N+1). Otherwise flags hold. flag_we with other src_sel is ignored.
- IDLE, accepted src_sel 01:
  - Latch dest_addr and reg_we; go WAIT_MEM; clear counter.
  - If mem_rvalid is already high in the accept cycle, it is ignored; a load always takes at least 1 wait cycle.
- WAIT_MEM:
  - Each cycle, if mem_rvalid: next edge rf_we per the latched reg_we/ZERO_REG rule, rf_wdata = mem_rdata, rf_waddr = latched addr, go IDLE.
  - Else counter++; when counter reaches MEM_TIMEOUT (i.e. MEM_TIMEOUT cycles without rvalid): mem_err <- 1, no write, go IDLE.
  - mem_rvalid in the same cycle as counter==MEM_TIMEOUT-1 counts as success.
- Back-to-back: a new instruction is accepted the cycle the FSM returns to IDLE (in_ready high that cycle). Full throughput of 1/cycle for non-load ops.
- rf_we, when not driven by a new write, returns to 0 the next cycle; rf_waddr/rf_wdata hold last value.
- mem_err clears only on reset.
- Reset mid-WAIT_MEM: abandon load, no write, IDLE, counter 0, mem_err 0.
- Arithmetic: counter width ceil(log2(MEM_TIMEOUT+1)); no width extension of data; carry taken only from alu_carry.

Test Plan:
- Reset, then ALU op with dest 3, alu_result 0x5A, reg_we=1, flag_we=1, zero=0, carry=1 -> next cycle rf_we=1, waddr=3, wdata=0x5A, flag_carry=1, flag_zero=0; following cycle rf_we=0.
- IMM to dest 0 with ZERO_REG=1, imm 0xFF -> rf_we stays 0. Same with dest 7 -> rf_we=1, wdata=0xFF. Flags unchanged.
- Load to dest 2, mem_rvalid after 3 cycles with 0x3C -> in_ready=0 for 3 cycles; rf_we=1, waddr=2, wdata=0x3C one cycle after rvalid; in_ready=1 again.
- Load with no mem_rvalid -> after 15 cycles mem_err=1, no rf_we, in_ready=1. mem_err persists until reset.
- Four consecutive ALU ops to dests 1,2,3,4 -> four consecutive rf_we pulses in order; fwd_* equal rf_* each cycle.
- Reset asserted during WAIT_MEM, then mem_rvalid pulse -> no rf_we; all outputs 0 after reset.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Result handshake bundle between the execute side and alu_writeback.
// master presents one completed instruction result, slave returns ready.
interface alu_writeback_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        src_sel;
  logic [ADDR_W-1:0] dest_addr;
  logic              reg_we;
  logic              flag_we;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic [DATA_W-1:0] imm_value;

  modport master (
    output in_valid,
    output src_sel,
    output dest_addr,
    output reg_we,
    output flag_we,
    output alu_result,
    output alu_zero,
    output alu_carry,
    output imm_value,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  src_sel,
    input  dest_addr,
    input  reg_we,
    input  flag_we,
    input  alu_result,
    input  alu_zero,
    input  alu_carry,
    input  imm_value,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage: selects ALU/MEM/IMM result, drives the register-file
// write port and forwarding bypass, registers flags, stalls on loads.
module alu_writeback #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int ZERO_REG    = 1
) (
  input  logic              clk,
  input  logic              reset,
  alu_writeback_if.slave    bus,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_we;

  logic              accept;
  logic              is_alu;
  logic              is_mem;
  logic              is_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flag_ld;
  logic              ld_start;
  logic              err_set;

  // A write to r0 is dropped when r0 is hardwired to zero.
  function automatic logic wr_ok(
    input logic              we,
    input logic [ADDR_W-1:0] addr
  );
    return we && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign bus.in_ready = (state == IDLE) && !reset;
  assign accept = bus.in_valid && bus.in_ready;

  assign is_alu = (bus.src_sel == 2'b00);
  assign is_mem = (bus.src_sel == 2'b01);
  assign is_imm = (bus.src_sel == 2'b10);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_addr   = bus.dest_addr;
    wr_data   = bus.alu_result;
    flag_ld   = 1'b0;
    ld_start  = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          flag_ld = bus.flag_we && is_alu;
          unique case (1'b1)
            is_mem: begin
              ld_start  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = WAIT_MEM;
            end
            is_alu: begin
              wr_en = wr_ok(bus.reg_we, bus.dest_addr);
            end
            is_imm: begin
              wr_en   = wr_ok(bus.reg_we, bus.dest_addr);
              wr_data = bus.imm_value;
            end
            default: begin
            end
          endcase
        end
      end
      WAIT_MEM: begin
        wr_addr = ld_addr;
        wr_data = mem_rdata;
        // rvalid on the last allowed cycle still wins over the timeout
        if (mem_rvalid) begin
          wr_en     = wr_ok(ld_we, ld_addr);
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_addr    <= '0;
      ld_we      <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      if (flag_ld) begin
        flag_zero  <= bus.alu_zero;
        flag_carry <= bus.alu_carry;
      end
      if (ld_start) begin
        ld_addr <= bus.dest_addr;
        ld_we   <= bus.reg_we;
      end
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_alu_writeback;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          flag_zero;
  logic          flag_carry;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic          mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic m_z = 1'b0;
  logic m_c = 1'b0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  alu_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  alu_writeback #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .MEM_TIMEOUT(TO),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .flag_zero(flag_zero),
    .flag_carry(flag_carry),
    .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr),
    .fwd_data(fwd_data),
    .mem_err(mem_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid   = 1'b0;
    bus.src_sel    = 2'b11;
    bus.dest_addr  = '0;
    bus.reg_we     = 1'b0;
    bus.flag_we    = 1'b0;
    bus.alu_result = '0;
    bus.alu_zero   = 1'b0;
    bus.alu_carry  = 1'b0;
    bus.imm_value  = '0;
  endtask

  task automatic put(
    input logic [1:0]    sel,
    input logic [AW-1:0] dest,
    input logic          rwe,
    input logic          fwe,
    input logic [DW-1:0] a,
    input logic          z,
    input logic          c,
    input logic [DW-1:0] imm
  );
    bus.in_valid   = 1'b1;
    bus.src_sel    = sel;
    bus.dest_addr  = dest;
    bus.reg_we     = rwe;
    bus.flag_we    = fwe;
    bus.alu_result = a;
    bus.alu_zero   = z;
    bus.alu_carry  = c;
    bus.imm_value  = imm;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry, mem_err,
         fwd_valid, fwd_addr, fwd_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b a=%0d d=%h z=%b c=%b err=%b fv=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry, mem_err, fwd_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b required 0", bus.in_ready);
    end
    reset = 1'b0;
    m_z = 1'b0;
    m_c = 1'b0;
    m_err = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_alu();
    put(2'b00, 3'd3, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h00);
    step();
    idle_in();
    m_z = 1'b0;
    m_c = 1'b1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry,
         fwd_valid, fwd_addr, fwd_data} !==
        {1'b1, 3'd3, 8'h5A, 1'b0, 1'b1, 1'b1, 3'd3, 8'h5A}) begin
      n_bad++;
      $display("FAIL alu_write: got we=%b a=%0d d=%h z=%b c=%b fwd=%b/%0d/%h, required 1/3/5a z0 c1",
               rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry,
               fwd_valid, fwd_addr, fwd_data);
    end
    step();
    n_cmp++;
    if ({rf_we, fwd_valid, rf_waddr, rf_wdata} !==
        {1'b0, 1'b0, 3'd3, 8'h5A}) begin
      n_bad++;
      $display("FAIL alu_pulse_end: got we=%b fv=%b a=%0d d=%h, required 0 0 3 5a",
               rf_we, fwd_valid, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_imm_zero();
    put(2'b10, 3'd0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF);
    step();
    idle_in();
    n_cmp++;
    if ({rf_we, fwd_valid, flag_zero, flag_carry} !==
        {1'b0, 1'b0, m_z, m_c}) begin
      n_bad++;
      $display("FAIL imm_r0: got we=%b fv=%b z=%b c=%b, required 0 0 %b %b",
               rf_we, fwd_valid, flag_zero, flag_carry, m_z, m_c);
    end
    put(2'b10, 3'd7, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF);
    step();
    idle_in();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
         flag_zero, flag_carry} !==
        {1'b1, 3'd7, 8'hFF, 1'b1, 3'd7, 8'hFF, m_z, m_c}) begin
      n_bad++;
      $display("FAIL imm_r7: got we=%b a=%0d d=%h z=%b c=%b, required 1 7 ff %b %b",
               rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry, m_z, m_c);
    end
    put(2'b11, 3'd5, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h22);
    step();
    idle_in();
    n_cmp++;
    if ({rf_we, flag_zero, flag_carry} !== {1'b0, m_z, m_c}) begin
      n_bad++;
      $display("FAIL src_none: got we=%b z=%b c=%b, required 0 %b %b",
               rf_we, flag_zero, flag_carry, m_z, m_c);
    end
  endtask

  task automatic run_load(
    input string         name,
    input logic [AW-1:0] dest,
    input int            lat,
    input logic [DW-1:0] ld
  );
    int low;
    int early;
    low = 0;
    early = 0;
    put(2'b01, dest, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    mem_rvalid = 1'b1;
    mem_rdata  = 8'hAA;
    step();
    mem_rvalid = 1'b0;
    // a competing op is offered while stalled and must not be taken
    put(2'b00, 3'd6, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= lat; k++) begin
      if (bus.in_ready === 1'b0 && rf_we === 1'b0) low++;
      if (mem_err !== m_err) early++;
      if (k == lat) begin
        idle_in();
        mem_rvalid = 1'b1;
        mem_rdata  = ld;
      end
      step();
      mem_rvalid = 1'b0;
    end
    n_cmp++;
    if (low != lat || early != 0) begin
      n_bad++;
      $display("FAIL %s_stall: got %0d stalled cycles (%0d err glitches), required %0d (0)",
               name, low, early, lat);
    end
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
         bus.in_ready, flag_zero, flag_carry, mem_err} !==
        {1'b1, dest, ld, 1'b1, dest, ld, 1'b1, m_z, m_c, m_err}) begin
      n_bad++;
      $display("FAIL %s_write: got we=%b a=%0d d=%h rdy=%b z=%b c=%b err=%b, required 1 %0d %h 1 %b %b %b",
               name, rf_we, rf_waddr, rf_wdata, bus.in_ready,
               flag_zero, flag_carry, mem_err, dest, ld, m_z, m_c, m_err);
    end
  endtask

  task automatic test_load();
    run_load("load3", 3'd2, 3, 8'h3C);
  endtask

  task automatic test_load_boundary();
    run_load("load_last", 3'd5, TO, 8'hC3);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      d = DW'($urandom);
      put(2'b00, AW'(i + 1), 1'b1, 1'b0, d, 1'b0, 1'b0, 8'h00);
      step();
      if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           bus.in_ready} === {1'b1, AW'(i + 1), d, 1'b1, AW'(i + 1), d, 1'b1})
        pulses++;
      else
        $display("FAIL b2b_op%0d: got we=%b a=%0d d=%h fwd=%b/%0d/%h, required 1 %0d %h",
                 i, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
                 i + 1, d);
    end
    idle_in();
    n_cmp++;
    if (pulses != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d good pulses required 4", pulses);
    end
    step();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: got we=%b required 0", rf_we);
    end
  endtask

  task automatic test_timeout();
    int low;
    int early;
    low = 0;
    early = 0;
    put(2'b01, 3'd5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    idle_in();
    for (int k = 1; k <= TO; k++) begin
      if (bus.in_ready === 1'b0 && rf_we === 1'b0) low++;
      if (mem_err !== m_err) early++;
      step();
    end
    m_err = 1'b1;
    n_cmp++;
    if (low != TO || early != 0) begin
      n_bad++;
      $display("FAIL timeout_stall: got %0d stalled (%0d early err), required %0d (0)",
               low, early, TO);
    end
    n_cmp++;
    if ({mem_err, rf_we, bus.in_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL timeout_abort: got err=%b we=%b rdy=%b, required 1 0 1",
               mem_err, rf_we, bus.in_ready);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 8'h55;
    step();
    mem_rvalid = 1'b0;
    put(2'b00, 3'd1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 8'h00);
    step();
    idle_in();
    step();
    n_cmp++;
    if ({mem_err, rf_we} !== 2'b10) begin
      n_bad++;
      $display("FAIL err_sticky: got err=%b we=%b, required 1 0", mem_err, rf_we);
    end
  endtask

  task automatic test_random();
    logic [1:0]    sel;
    logic [AW-1:0] dest;
    logic          rwe;
    logic          fwe;
    logic [DW-1:0] a;
    logic          z;
    logic          c;
    logic [DW-1:0] imm;
    logic          ewe;
    logic [DW-1:0] edata;
    int            lat;
    int            stall_bad;
    for (int t = 0; t < 250; t++) begin
      sel  = 2'($urandom);
      dest = AW'($urandom);
      rwe  = 1'($urandom);
      fwe  = 1'($urandom);
      a    = DW'($urandom);
      z    = 1'($urandom);
      c    = 1'($urandom);
      imm  = DW'($urandom);
      ewe  = 1'b0;
      edata = '0;
      if ($urandom_range(0, 3) == 0) begin
        idle_in();
        bus.src_sel = sel;
        mem_rvalid = 1'($urandom);
        step();
        mem_rvalid = 1'b0;
      end else if (sel != 2'b01) begin
        put(sel, dest, rwe, fwe, a, z, c, imm);
        mem_rvalid = 1'($urandom);
        mem_rdata  = DW'($urandom);
        step();
        mem_rvalid = 1'b0;
        idle_in();
        ewe   = rwe && sel != 2'b11 && dest != 0;
        edata = (sel == 2'b00) ? a : imm;
        if (fwe && sel == 2'b00) begin
          m_z = z;
          m_c = c;
        end
      end else begin
        lat   = $urandom_range(1, TO + 1);
        edata = DW'($urandom);
        stall_bad = 0;
        put(2'b01, dest, rwe, fwe, a, z, c, imm);
        mem_rvalid = 1'($urandom);
        mem_rdata  = DW'($urandom);
        step();
        mem_rvalid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
          if (bus.in_ready !== 1'b0 || rf_we !== 1'b0) stall_bad++;
          put(2'($urandom), AW'($urandom), 1'b1, 1'b1,
              DW'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
          if (k == lat) begin
            mem_rvalid = 1'b1;
            mem_rdata  = edata;
          end
          step();
          mem_rvalid = 1'b0;
          if (k == lat) break;
        end
        idle_in();
        n_cmp++;
        if (stall_bad != 0) begin
          n_bad++;
          $display("FAIL rand_stall t=%0d: %0d cycles not stalled, required 0",
                   t, stall_bad);
        end
        if (lat > TO) m_err = 1'b1;
        ewe = (lat <= TO) && rwe && dest != 0;
      end
      n_cmp++;
      if ({rf_we, fwd_valid, bus.in_ready, flag_zero, flag_carry, mem_err} !==
          {ewe, ewe, 1'b1, m_z, m_c, m_err}) begin
        n_bad++;
        $display("FAIL rand_ctl t=%0d: got we=%b fv=%b rdy=%b z=%b c=%b err=%b, required %b %b 1 %b %b %b",
                 t, rf_we, fwd_valid, bus.in_ready, flag_zero, flag_carry,
                 mem_err, ewe, ewe, m_z, m_c, m_err);
      end
      if (ewe) begin
        n_cmp++;
        if ({rf_waddr, rf_wdata, fwd_addr, fwd_data} !==
            {dest, edata, dest, edata}) begin
          n_bad++;
          $display("FAIL rand_data t=%0d: got a=%0d d=%h fwd=%0d/%h, required %0d %h",
                   t, rf_waddr, rf_wdata, fwd_addr, fwd_data, dest, edata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    put(2'b01, 3'd4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    idle_in();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_z = 1'b0;
    m_c = 1'b0;
    m_err = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 8'h77;
    step();
    mem_rvalid = 1'b0;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry, mem_err,
         fwd_valid, fwd_addr, fwd_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_load: got we=%b a=%0d d=%h z=%b c=%b err=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, flag_zero, flag_carry, mem_err);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_load_ready: got %b required 1", bus.in_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    test_reset();
    test_alu();
    test_imm_zero();
    test_load();
    test_load_boundary();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
